// File: rtl/display_scan_scheduler.sv
// Multiplexed seven-segment scan scheduler.
// One shared decoder is time-shared across NUM_DIGITS digits. Each digit gets a
// slot made of a blanking interval (all drivers off) followed by a dwell
// interval (its driver on if enabled). Displayed nibbles come from a shadow
// register that is only reloaded on the frame boundary, with a one-cycle ack
// back to the producer.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_BLANK | all digit drivers off; decoder input settles to the next digit
// ST_DWELL | driver of the current digit follows its enable bit
module display_scan_scheduler #(
  parameter int NUM_DIGITS   = 2,
  parameter int DWELL_CYCLES = 240000,
  parameter int BLANK_CYCLES = 4800,
  parameter int CNT_WIDTH    = 24,
  localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                      internal_oscillator,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   digit_values,
  input  logic [NUM_DIGITS-1:0]     digit_enable,
  input  logic                      update,
  output logic                      update_ack,
  output logic [3:0]                nibble_sel,
  output logic [IDX_W-1:0]          active_digit,
  output logic [NUM_DIGITS-1:0]     transistor,
  output logic                      frame_done
);

  localparam logic [CNT_WIDTH-1:0] BLANK_LAST = CNT_WIDTH'(BLANK_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DWELL_LAST = CNT_WIDTH'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DWELL = 1'b1
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_WIDTH-1:0]    cnt, cnt_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic [4*NUM_DIGITS-1:0] shadow, shadow_nxt;
  logic [NUM_DIGITS-1:0]   transistor_nxt;
  logic [3:0]              nibble_nxt;
  logic [IDX_W-1:0]        active_nxt;
  logic                    ack_nxt;
  logic                    frame_nxt;
  logic                    blank_tc;
  logic                    dwell_tc;
  logic                    slot_end;
  logic                    boundary;

  // Next-state, slot sequencing, shadow capture and registered-output values.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt + CNT_WIDTH'(1);
    idx_nxt        = idx;
    shadow_nxt     = shadow;
    transistor_nxt = '0;
    nibble_nxt     = nibble_sel;
    active_nxt     = active_digit;
    ack_nxt        = 1'b0;
    frame_nxt      = 1'b0;

    blank_tc = (cnt == BLANK_LAST);
    dwell_tc = (cnt == DWELL_LAST);
    slot_end = (state == ST_DWELL) && dwell_tc;
    boundary = slot_end && (idx == IDX_LAST);

    case (state)
      ST_BLANK: begin
        if (blank_tc) begin
          state_nxt = ST_DWELL;
          cnt_nxt   = '0;
        end
      end
      ST_DWELL: begin
        if (dwell_tc) begin
          state_nxt = ST_BLANK;
          cnt_nxt   = '0;
          idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end
      end
      default: begin
        state_nxt = ST_BLANK;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase

    // Capture lands on the last dwell cycle of the last digit only, so a
    // frame is always shown from a single consistent snapshot.
    if (boundary) begin
      frame_nxt = 1'b1;
      if (update) begin
        shadow_nxt = digit_values;
        ack_nxt    = 1'b1;
      end
    end

    // Decoder input moves to the new digit as blanking starts, and uses the
    // freshly captured shadow when this is also the frame boundary.
    if (slot_end) begin
      nibble_nxt = shadow_nxt[4*int'(idx_nxt) +: 4];
      active_nxt = idx_nxt;
    end

    // Driver is registered from the next state so it is off for the whole
    // blanking interval and tracks enable with one cycle of latency.
    if (state_nxt == ST_DWELL) begin
      transistor_nxt[idx_nxt] = digit_enable[idx_nxt];
    end
  end

  // State and output registers; reset forces all drivers off immediately.
  always_ff @(posedge internal_oscillator or posedge reset) begin
    if (reset) begin
      state        <= ST_BLANK;
      cnt          <= '0;
      idx          <= '0;
      shadow       <= '0;
      transistor   <= '0;
      nibble_sel   <= '0;
      active_digit <= '0;
      update_ack   <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      idx          <= idx_nxt;
      shadow       <= shadow_nxt;
      transistor   <= transistor_nxt;
      nibble_sel   <= nibble_nxt;
      active_digit <= active_nxt;
      update_ack   <= ack_nxt;
      frame_done   <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Scoreboard bench for display_scan_scheduler with a cycle-arithmetic model.
module tb_display_scan_scheduler;

  localparam int ND    = 2;
  localparam int DW    = 8;
  localparam int BL    = 2;
  localparam int SLOT  = BL + DW;
  localparam int FRAME = ND * SLOT;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [4*ND-1:0] digit_values = '0;
  logic [ND-1:0] digit_enable = '0;
  logic          update = 1'b0;
  logic          update_ack;
  logic [3:0]    nibble_sel;
  logic [0:0]    active_digit;
  logic [ND-1:0] transistor;
  logic          frame_done;

  display_scan_scheduler #(
    .NUM_DIGITS  (ND),
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BL),
    .CNT_WIDTH   (4)
  ) dut (
    .internal_oscillator(clk),
    .reset              (reset),
    .digit_values       (digit_values),
    .digit_enable       (digit_enable),
    .update             (update),
    .update_ack         (update_ack),
    .nibble_sel         (nibble_sel),
    .active_digit       (active_digit),
    .transistor         (transistor),
    .frame_done         (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ND-1:0] trans;
    logic [3:0]    nib;
    int            act;
  } exp_t;

  typedef struct {
    int   cyc;
    logic ack;
  } ev_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   t = 0;
  int   mon_cyc = 0;
  bit   mon_on = 1'b0;
  bit   acked_now = 1'b0;
  logic [3:0] mshadow [ND];
  exp_t exp_q[$];
  ev_t  ev_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, t);
    end
  endtask

  // Expected outputs at cycle tc, from slot arithmetic only.
  function automatic exp_t predict(input int tc, input logic [ND-1:0] en_prev);
    exp_t e;
    int slot, pos, dig;
    slot = tc / SLOT;
    pos  = tc % SLOT;
    dig  = slot % ND;
    e.trans = '0;
    if (pos >= BL && en_prev[dig]) e.trans[dig] = 1'b1;
    e.nib = mshadow[dig];
    e.act = dig;
    return e;
  endfunction

  // Inputs en/upd/vals were held during cycle t; advance to t+1.
  task automatic model_advance(input logic [ND-1:0] en, input logic upd, input logic [4*ND-1:0] vals);
    ev_t ev;
    acked_now = 1'b0;
    if (t % FRAME == FRAME - 1) begin
      if (upd) begin
        for (int i = 0; i < ND; i++) mshadow[i] = vals[4*i +: 4];
        acked_now = 1'b1;
      end
      ev.cyc = t + 1;
      ev.ack = upd;
      ev_q.push_back(ev);
    end
    t++;
    exp_q.push_back(predict(t, en));
  endtask

  task automatic step(input logic [ND-1:0] en, input logic upd, input logic [4*ND-1:0] vals);
    digit_enable = en;
    update       = upd;
    digit_values = vals;
    @(posedge clk);
    #1;
    model_advance(en, upd, vals);
  endtask

  task automatic do_reset();
    mon_on = 1'b0;
    reset  = 1'b1;
    update = 1'b0;
    exp_q.delete();
    ev_q.delete();
    repeat (5) begin
      @(negedge clk);
      chk("rst_transistor", transistor, 0);
      chk("rst_nibble", nibble_sel, 0);
      chk("rst_active", active_digit, 0);
      chk("rst_ack", update_ack, 0);
      chk("rst_frame_done", frame_done, 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    t = 0;
    for (int i = 0; i < ND; i++) mshadow[i] = 4'h0;
    exp_q.push_back(predict(0, '0));
    mon_on = 1'b1;
  endtask

  exp_t mon_e;
  ev_t  mon_ev;

  // Monitor: per-cycle outputs against the queue, pulses against the event queue.
  always @(negedge clk) begin
    if (mon_on) begin
      if (exp_q.size() == 0) begin
        chk("exp_queue_underflow", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("transistor", transistor, mon_e.trans);
        chk("nibble_sel", nibble_sel, mon_e.nib);
        chk("active_digit", active_digit, mon_e.act);
      end
      if (frame_done || update_ack) begin
        if (ev_q.size() == 0) begin
          chk("unexpected_pulse", {frame_done, update_ack}, 0);
        end else begin
          mon_ev = ev_q.pop_front();
          chk("frame_done_cycle", mon_cyc, mon_ev.cyc);
          chk("frame_done", frame_done, 1);
          chk("update_ack", update_ack, mon_ev.ack);
        end
      end else if (ev_q.size() > 0 && ev_q[0].cyc <= mon_cyc) begin
        mon_ev = ev_q.pop_front();
        chk("missed_frame_done", 0, 1);
      end
      chk("onehot", ($countones(transistor) <= 1) ? 1 : 0, 1);
      chk("ack_with_frame", update_ack & ~frame_done, 0);
      mon_cyc = mon_cyc + 1;
    end else begin
      mon_cyc = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got_ack;
    bit req;
    logic [7:0] rv;
    logic [1:0] ren;

    // Reset, then update handshake with values A5 raised at cycle 3.
    do_reset();
    got_ack = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step(2'b11, (c >= 3) && !got_ack, got_ack ? 8'h3C : 8'hA5);
      if (acked_now) got_ack = 1'b1;
    end

    // Update raised exactly on the boundary cycle is captured.
    for (int k = 0; k < FRAME && (t % FRAME != FRAME - 1); k++) step(2'b11, 1'b0, 8'h11);
    step(2'b11, 1'b1, 8'h7E);
    chk("boundary_capture", acked_now, 1);

    // Update raised just after the boundary waits a whole frame.
    got_ack = 1'b0;
    for (int k = 0; k < 2 * FRAME && !got_ack; k++) begin
      step(2'b11, 1'b1, 8'h42);
      if (acked_now) got_ack = 1'b1;
    end
    chk("late_update_acked", got_ack, 1);

    // Digit 0 masked for a full frame.
    for (int k = 0; k < FRAME && (t % FRAME != 0); k++) step(2'b11, 1'b0, 8'h00);
    for (int k = 0; k < FRAME; k++) step(2'b10, 1'b0, 8'h00);

    // Reset in the middle of digit 1 dwell.
    for (int k = 0; k < FRAME && (t % FRAME != 15); k++) step(2'b11, 1'b0, 8'h00);
    mon_on = 1'b0;
    chk("pre_reset_drive", transistor, exp_q[$].trans);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_transistor", transistor, 0);
    chk("async_rst_nibble", nibble_sel, 0);
    chk("async_rst_active", active_digit, 0);
    do_reset();
    for (int c = 0; c < 2 * FRAME; c++) step(2'b11, 1'b0, 8'hFF);

    // Random stress with a well-behaved requester that sometimes keeps update high.
    req = 1'b0;
    rv  = 8'h00;
    ren = 2'b11;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 7) == 0) ren = 2'($urandom);
      if (!req && $urandom_range(0, 15) == 0) begin
        req = 1'b1;
        rv  = 8'($urandom);
      end
      step(ren, req, rv);
      if (acked_now && $urandom_range(0, 3) != 0) req = 1'b0;
    end

    @(negedge clk);
    #1;
    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/display_scan_scheduler.md
Name: display_scan_scheduler

Overview:
- Time-shares one seven-segment decoder and segment bus among NUM_DIGITS common-anode/cathode digits.
- Sequences the digit-select transistors with a blanking (dead-time) interval between digits to remove ghosting.
- Presents the selected digit's nibble to the shared decoder.
- Double-buffers the displayed values so updates land only on frame boundaries, with a request/ack handshake to the value producer.

Parameters:
- NUM_DIGITS, 2, number of multiplexed digits (2..8).
- DWELL_CYCLES, 240000, clock cycles each digit is driven (≥1).
- BLANK_CYCLES, 4800, clock cycles all transistors are off before each digit (≥1).
- CNT_WIDTH, 24, slot counter width; must hold max(DWELL_CYCLES, BLANK_CYCLES)-1.

Ports:
- internal_oscillator  input   1             system clock, 48 MHz HSOSC.
- reset                input   1             asynchronous, active-high reset.
- digit_values         input   4*NUM_DIGITS  nibble i at bits [4i+3:4i]; sampled only on capture.
- digit_enable         input   NUM_DIGITS    per-digit display enable, sampled every cycle.
- update               input   1             level request to capture digit_values into the shadow register.
- update_ack           output  1             one-cycle pulse: capture performed this cycle.
- nibble_sel           output  4             shadow nibble of the current digit, to the shared decoder.
- active_digit         output  clog2(NUM_DIGITS) (min 1)  index of the current slot.
- transistor           output  NUM_DIGITS    digit drive, active-high; at most one bit set.
- frame_done           output  1             one-cycle pulse at end of each frame.

Behaviour:
- All outputs and state are registered.
- Reset (async assert, sync release) sets: state=BLANK, index=0, counter=0, shadow=0, transistor=0, nibble_sel=0, active_digit=0, update_ack=0, frame_done=0.
- FSM has two states, BLANK and DWELL.
  - BLANK: transistor=0. Counter runs 0..BLANK_CYCLES-1. At BLANK_CYCLES-1, go to DWELL and clear counter.
  - DWELL: transistor[index]=digit_enable[index]; all other bits are 0. Counter runs 0..DWELL_CYCLES-1. At DWELL_CYCLES-1:
    - go to BLANK and clear counter;
    - index = (index==NUM_DIGITS-1) ? 0 : index+1.
- nibble_sel and active_digit update on the BLANK entry cycle to the new index, so the decoder settles during blanking.
- Slot length = BLANK_CYCLES+DWELL_CYCLES. Frame length = NUM_DIGITS*slot. Defaults at 48 MHz give ≈98 Hz per frame.
- A disabled digit keeps its time slot with transistor held at 0. Refresh rate and brightness are independent of the enable pattern.
- A digit_enable change during DWELL takes effect on transistor on the next cycle.
- Frame boundary = last DWELL cycle of index NUM_DIGITS-1. On that cycle:
  - frame_done=1 on the next cycle (registered pulse, width 1).
  - If update=1 on that cycle: shadow <= digit_values, and update_ack=1 on the next cycle.
  - The new values appear on nibble_sel from the index-0 BLANK entry onward.
- update outside the boundary cycle is ignored until the next boundary. The requester holds update until ack, then drops it.
  - If update stays high after ack, a fresh capture occurs every frame boundary.
- Invariant: transistor is never multi-hot. It is zero throughout every BLANK interval, including the first after reset.
- Reset mid-operation: transistor goes to 0 immediately (asynchronously), the shadow is cleared, and scanning restarts at index 0 BLANK.

Test Plan:
- Reset/idle (NUM_DIGITS=2, DWELL=8, BLANK=2):
  - hold reset 5 cycles → all outputs 0.
  - after release, transistor=0 for cycles 0-1, transistor=2'b01 for cycles 2-9, 0 for cycles 10-11, 2'b10 for cycles 12-19, frame_done=1 only at cycle 20.
- Update handshake: digit_values=8'hA5, update raised at cycle 3 → update_ack=1 at cycle 20 only; after that frame, nibble_sel=4'h5 during digit 0 and 4'hA during digit 1. Before that, nibble_sel=0.
- Boundary race: update asserted exactly on the cycle-19 boundary → captured (ack at 20). Update asserted at cycle 20 → no ack until cycle 40.
- Enable mask: digit_enable=2'b10 → transistor stays 0 during the digit-0 slot, 2'b10 during the digit-1 slot, and frame period is still 20 cycles.
- Reset mid-DWELL: assert reset at cycle 15 (digit 1 on) → transistor=0 in the same cycle without a clock edge, shadow=0, and the sequence restarts as in the first scenario.
- Random stress, 10k cycles, random enable/update → assertion that popcount(transistor)≤1 always, 0 in BLANK, and every ack coincides with frame_done.
